// File: rtl/xoshiro_pkg.sv
// Shared types, jump polynomial and scrambler helpers for the xoshiro256** generator.
// The JUMP state exists only when XOSHIRO_JUMP_EN is defined.
package xoshiro_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEED,
      ST_CHECK,
      ST_RUN
`ifdef XOSHIRO_JUMP_EN
      , ST_JUMP
`endif
   } state_t;

   localparam logic [63:0] MUL_A = 64'd5;
   localparam logic [63:0] MUL_B = 64'd9;

   localparam logic [63:0] J0 = 64'h180E_C6D3_3CFD_0ABA;
   localparam logic [63:0] J1 = 64'hD5A6_1266_F0C9_392C;
   localparam logic [63:0] J2 = 64'hA958_2618_E03F_C9AA;
   localparam logic [63:0] J3 = 64'h39AB_DC45_29B1_661C;
   localparam logic [3:0][63:0] JUMP_POLY = {J3, J2, J1, J0};

   function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned k);
      return (x << k) | (x >> (64 - k));
   endfunction

   // The ** scrambler only looks at word 1 of the state.
   function automatic logic [63:0] scramble(input logic [63:0] s1);
      logic [63:0] p;
      p = s1 * MUL_A;
      return rotl64(p, 7) * MUL_B;
   endfunction

endpackage

// File: rtl/xoshiro256ss_step.sv
// Combinational xoshiro256** step: next state and scrambled output of the current state.
module xoshiro256ss_step
   import xoshiro_pkg::*;
(
   input  logic [3:0][63:0] s,
   output logic [3:0][63:0] s_next,
   output logic [63:0]      result
);

   logic [63:0] t, x2, x3;

   always_comb begin
      t         = s[1] << 17;
      x2        = s[2] ^ s[0];
      x3        = s[3] ^ s[1];
      s_next[1] = s[1] ^ x2;
      s_next[0] = s[0] ^ x3;
      s_next[2] = x2 ^ t;
      s_next[3] = rotl64(x3, 45);
      result    = scramble(s[1]);
   end

endmodule

// File: rtl/xoshiro256ss_gen.sv
// xoshiro256** generator seeded from an upstream splitmix64 with SM_LAT-cycle latency.
// Define XOSHIRO_JUMP_EN to add jump_req and the 2^128 jump sequence.
module xoshiro256ss_gen
   import xoshiro_pkg::*;
#(
   parameter int unsigned SM_LAT = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        seed_start,
   output logic        sm_en,
   input  logic [63:0] sm_out,
   output logic [63:0] rand_data,
   output logic        rand_valid,
   input  logic        rand_ready,
   output logic        busy
`ifdef XOSHIRO_JUMP_EN
   ,input logic        jump_req
`endif
);

   state_t           state;
   logic [3:0][63:0] s, s_in, s_next;
   logic [63:0]      step_res;
   logic [1:0]       en_cnt, cap_cnt;
   logic [SM_LAT:1]  vld_pipe;
`ifdef XOSHIRO_JUMP_EN
   logic [3:0][63:0] acc, acc_upd;
   logic [7:0]       jmp_cnt;
   logic             jbit;
`endif

   // An all-zero seed is a fixed point; only reachable in CHECK.
   always_comb begin
      s_in = s;
      if (s == '0) s_in[0] = 64'h1;
   end

   xoshiro256ss_step u_step (
      .s      (s_in),
      .s_next (s_next),
      .result (step_res)
   );

`ifdef XOSHIRO_JUMP_EN
   always_comb begin
      jbit    = JUMP_POLY[jmp_cnt[7:6]][jmp_cnt[5:0]];
      acc_upd = jbit ? (acc ^ s) : acc;
   end
`endif

   // Tracks which cycles carry a requested splitmix word on sm_out.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[1] <= sm_en;
         for (int i = 2; i <= SM_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         s          <= '0;
         en_cnt     <= '0;
         cap_cnt    <= '0;
         rand_data  <= '0;
         rand_valid <= 1'b0;
         sm_en      <= 1'b0;
         busy       <= 1'b0;
`ifdef XOSHIRO_JUMP_EN
         acc        <= '0;
         jmp_cnt    <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (seed_start) begin
               state   <= ST_SEED;
               sm_en   <= 1'b1;
               en_cnt  <= '0;
               cap_cnt <= '0;
               busy    <= 1'b1;
            end
            ST_SEED: begin
               if (sm_en) begin
                  if (en_cnt == 2'd3) sm_en <= 1'b0;
                  else                en_cnt <= en_cnt + 2'd1;
               end
               if (vld_pipe[SM_LAT]) begin
                  s[cap_cnt] <= sm_out;
                  cap_cnt    <= cap_cnt + 2'd1;
                  if (cap_cnt == 2'd3) state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               s          <= s_in;
               rand_data  <= step_res;
               rand_valid <= 1'b1;
               busy       <= 1'b0;
               state      <= ST_RUN;
            end
            ST_RUN: begin
               if (seed_start) begin
                  state      <= ST_SEED;
                  sm_en      <= 1'b1;
                  en_cnt     <= '0;
                  cap_cnt    <= '0;
                  rand_valid <= 1'b0;
                  busy       <= 1'b1;
`ifdef XOSHIRO_JUMP_EN
               end else if (jump_req) begin
                  state      <= ST_JUMP;
                  acc        <= '0;
                  jmp_cnt    <= '0;
                  rand_valid <= 1'b0;
                  busy       <= 1'b1;
`endif
               end else if (rand_ready) begin
                  s         <= s_next;
                  rand_data <= scramble(s_next[1]);
               end
            end
`ifdef XOSHIRO_JUMP_EN
            ST_JUMP: begin
               if (jmp_cnt == 8'hFF) begin
                  s          <= acc_upd;
                  rand_data  <= scramble(acc_upd[1]);
                  rand_valid <= 1'b1;
                  busy       <= 1'b0;
                  state      <= ST_RUN;
               end else begin
                  acc     <= acc_upd;
                  s       <= s_next;
                  jmp_cnt <= jmp_cnt + 8'd1;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xoshiro256ss_gen.sv
// Self-checking bench for xoshiro256ss_gen against a reference xoshiro256** model.
// Exercises the jump path when XOSHIRO_JUMP_EN is defined.
module tb_xoshiro256ss_gen;

   localparam int SM_LAT = 1;

   logic        clk = 1'b0;
   logic        rst, seed_start, sm_en, rand_valid, rand_ready, busy;
   logic [63:0] sm_out = '0;
   logic [63:0] rand_data;
`ifdef XOSHIRO_JUMP_EN
   logic        jump_req;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] word_q[$];
   logic [7:0]  en_hist = '0;
   logic [8:0]  en_tap;
   logic [63:0] m [4];

   always #5 clk = ~clk;

   xoshiro256ss_gen #(.SM_LAT(SM_LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .seed_start (seed_start),
      .sm_en      (sm_en),
      .sm_out     (sm_out),
      .rand_data  (rand_data),
      .rand_valid (rand_valid),
      .rand_ready (rand_ready),
      .busy       (busy)
`ifdef XOSHIRO_JUMP_EN
      ,.jump_req  (jump_req)
`endif
   );

   // Upstream splitmix stand-in: a word appears SM_LAT cycles after each sm_en cycle.
   assign en_tap = {en_hist, sm_en};
   always @(posedge clk) begin
      en_hist <= {en_hist[6:0], sm_en};
      if (en_tap[SM_LAT-1]) sm_out <= (word_q.size() > 0) ? word_q.pop_front() : 64'h0;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] rl(input logic [63:0] x, input int k);
      return (x << k) | (x >> (64 - k));
   endfunction

   function automatic logic [63:0] m_res();
      logic [63:0] p;
      p = m[1] * 64'd5;
      return rl(p, 7) * 64'd9;
   endfunction

   task automatic m_adv();
      logic [63:0] t;
      t = m[1] << 17;
      m[2] ^= m[0];
      m[3] ^= m[1];
      m[1] ^= m[2];
      m[0] ^= m[3];
      m[2] ^= t;
      m[3] = rl(m[3], 45);
   endtask

   task automatic m_seed(input logic [63:0] w0, w1, w2, w3);
      m[0] = w0; m[1] = w1; m[2] = w2; m[3] = w3;
      if ((w0 | w1 | w2 | w3) == 64'h0) m[0] = 64'h1;
   endtask

   task automatic start_seed(input logic [63:0] w0, w1, w2, w3);
      word_q.delete();
      word_q.push_back(w0); word_q.push_back(w1);
      word_q.push_back(w2); word_q.push_back(w3);
      m_seed(w0, w1, w2, w3);
      @(negedge clk) seed_start = 1'b1;
      @(negedge clk) seed_start = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int cyc = 0;
      while (!rand_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (!rand_valid) begin
         n_fail++;
         $display("FAIL %s_timeout: rand_valid=%0b after %0d cycles, required 1", tag, rand_valid, cyc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; seed_start = 1'b0; rand_ready = 1'b0;
`ifdef XOSHIRO_JUMP_EN
      jump_req = 1'b0;
`endif
      repeat (2) @(negedge clk);
      n_checks++;
      if (rand_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rand_valid); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++;
      if (sm_en !== 1'b0) begin n_fail++; $display("FAIL reset_sm_en: got %b want 0", sm_en); end
      n_checks++;
      if (rand_data !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", rand_data); end
      rst = 1'b0;
      rand_ready = 1'b1;
`ifdef XOSHIRO_JUMP_EN
      jump_req = 1'b1;
`endif
      repeat (5) begin
         @(negedge clk);
         n_checks++;
         if ({busy, rand_valid, sm_en} !== 3'b000) begin
            n_fail++; $display("FAIL idle_ignore: busy/valid/sm_en=%b want 000", {busy, rand_valid, sm_en});
         end
      end
      rand_ready = 1'b0;
`ifdef XOSHIRO_JUMP_EN
      jump_req = 1'b0;
`endif
   endtask

   task automatic test_latency();
      logic ee, ev, eb;
      word_q.delete();
      word_q.push_back(64'd1); word_q.push_back(64'd2);
      word_q.push_back(64'd3); word_q.push_back(64'd4);
      m_seed(64'd1, 64'd2, 64'd3, 64'd4);
      @(negedge clk) seed_start = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         seed_start = 1'b0;
         ee = (c >= 1 && c <= 4);
         ev = (c >= 6 + SM_LAT);
         eb = (c <= 5 + SM_LAT);
         n_checks++;
         if ({sm_en, rand_valid, busy} !== {ee, ev, eb}) begin
            n_fail++;
            $display("FAIL latency_c%0d: sm_en/valid/busy=%b want %b", c, {sm_en, rand_valid, busy}, {ee, ev, eb});
         end
      end
      n_checks++;
      if (rand_data !== 64'd11520 || rand_data !== m_res()) begin
         n_fail++; $display("FAIL first_word: got %0d want 11520", rand_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_w [3];
      exp_w[0] = 64'd11520; exp_w[1] = 64'd0; exp_w[2] = 64'd1509978240;
      rand_ready = 1'b1;
      for (int i = 1; i < 3; i++) begin
         @(negedge clk);
         m_adv();
         n_checks++;
         if (rand_valid !== 1'b1 || rand_data !== exp_w[i] || rand_data !== m_res()) begin
            n_fail++; $display("FAIL b2b_%0d: valid=%b data=%0d want 1/%0d", i, rand_valid, rand_data, exp_w[i]);
         end
      end
      rand_ready = 1'b0;
   endtask

   task automatic test_hold_and_restart();
      start_seed(64'd1, 64'd2, 64'd3, 64'd4);
      n_checks++;
      if (rand_valid !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL restart_drop: valid=%b busy=%b want 0/1", rand_valid, busy);
      end
      wait_valid("hold");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_checks++;
         if (rand_valid !== 1'b1 || rand_data !== 64'd11520) begin
            n_fail++; $display("FAIL hold_%0d: valid=%b data=%0d want 1/11520", i, rand_valid, rand_data);
         end
      end
      rand_ready = 1'b1;
      @(negedge clk);
      rand_ready = 1'b0;
      n_checks++;
      if (rand_data !== 64'd0) begin n_fail++; $display("FAIL hold_release: got %0d want 0", rand_data); end
   endtask

   task automatic test_zero_seed();
      start_seed(64'd0, 64'd0, 64'd0, 64'd0);
      wait_valid("zero");
      n_checks++;
      if (rand_data !== 64'd0) begin n_fail++; $display("FAIL zero_w0: got %0d want 0", rand_data); end
      rand_ready = 1'b1;
      @(negedge clk);
      rand_ready = 1'b0;
      n_checks++;
      if (rand_data !== 64'd5760) begin n_fail++; $display("FAIL zero_w1: got %0d want 5760", rand_data); end
   endtask

   task automatic test_reset_mid_seed();
      word_q.delete();
      repeat (4) word_q.push_back(64'h9999);
      @(negedge clk) seed_start = 1'b1;
      @(negedge clk) seed_start = 1'b0;
      @(negedge clk);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      n_checks++;
      if ({sm_en, busy, rand_valid} !== 3'b000) begin
         n_fail++; $display("FAIL midseed_rst: sm_en/busy/valid=%b want 000", {sm_en, busy, rand_valid});
      end
      start_seed(64'd1, 64'd2, 64'd3, 64'd4);
      wait_valid("midseed");
      n_checks++;
      if (rand_data !== 64'd11520) begin n_fail++; $display("FAIL midseed_w0: got %0d want 11520", rand_data); end
      rand_ready = 1'b1;
      @(negedge clk);
      rand_ready = 1'b0;
      n_checks++;
      if (rand_data !== 64'd0) begin n_fail++; $display("FAIL midseed_w1: got %0d want 0", rand_data); end
   endtask

   task automatic test_random();
      logic [63:0] w [4];
      logic        rdy;
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 4; k++) w[k] = {$urandom, $urandom};
         start_seed(w[0], w[1], w[2], w[3]);
         wait_valid("random");
         for (int i = 0; i < 60; i++) begin
            n_checks++;
            if (rand_valid !== 1'b1 || rand_data !== m_res()) begin
               n_fail++;
               $display("FAIL random_r%0d_i%0d: valid=%b data=%0h want 1/%0h", r, i, rand_valid, rand_data, m_res());
            end
            rdy = 1'($urandom_range(0, 1));
            rand_ready = rdy;
            @(negedge clk);
            if (rdy) m_adv();
         end
         rand_ready = 1'b0;
      end
   endtask

`ifdef XOSHIRO_JUMP_EN
   task automatic test_jump();
      logic [63:0] jp [4];
      logic [63:0] a [4];
      int          cnt;
      jp[0] = 64'h180EC6D33CFD0ABA; jp[1] = 64'hD5A61266F0C9392C;
      jp[2] = 64'hA9582618E03FC9AA; jp[3] = 64'h39ABDC4529B1661C;
      start_seed(64'd1, 64'd2, 64'd3, 64'd4);
      wait_valid("jump");
      for (int k = 0; k < 4; k++) a[k] = 64'h0;
      for (int wi = 0; wi < 4; wi++)
         for (int b = 0; b < 64; b++) begin
            if (jp[wi][b]) for (int k = 0; k < 4; k++) a[k] ^= m[k];
            m_adv();
         end
      for (int k = 0; k < 4; k++) m[k] = a[k];
      @(negedge clk) jump_req = 1'b1;
      @(negedge clk) jump_req = 1'b0;
      cnt = 0;
      while (busy && cnt < 400) begin
         cnt++;
         @(negedge clk);
      end
      n_checks++;
      if (cnt != 256) begin n_fail++; $display("FAIL jump_busy: got %0d cycles want 256", cnt); end
      n_checks++;
      if (rand_valid !== 1'b1 || rand_data !== m_res()) begin
         n_fail++; $display("FAIL jump_data: valid=%b data=%0h want 1/%0h", rand_valid, rand_data, m_res());
      end
      rand_ready = 1'b1;
      @(negedge clk);
      rand_ready = 1'b0;
      m_adv();
      n_checks++;
      if (rand_data !== m_res()) begin
         n_fail++; $display("FAIL jump_next: got %0h want %0h", rand_data, m_res());
      end
   endtask
`endif

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_hold_and_restart();
      test_zero_seed();
      test_reset_mid_seed();
      test_random();
`ifdef XOSHIRO_JUMP_EN
      test_jump();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
